// File: rtl/rf_ctrl_pkg.sv
// Shared types and widths for the register-file writeback control path.
// The pending-write scoreboard is enabled with the RF_SCOREBOARD_EN macro.
package rf_ctrl_pkg;
   localparam int REG_IDX_W     = 5;
   localparam int DATA_W        = 32;
   localparam int NUM_REGS      = 32;
   localparam int CNT_W_DEFAULT = 2;

   typedef struct packed {
      logic [REG_IDX_W-1:0] reg_idx;
      logic [DATA_W-1:0]    data;
   } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_i and
// wraps modulo NREQ, so the most recently served requester has lowest priority.
module rr_arbiter #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] last_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [$clog2(NREQ)-1:0] idx_o,
   output logic                    valid_o
);
   localparam int IDX_W = $clog2(NREQ);

   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDX_W'((int'(last_i) + k) % NREQ);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
      valid_o = found;
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port with a registered write
// triple; RF_SCOREBOARD_EN adds per-register pending-write counters for RAW stalls.
module regfile_wb_arbiter
   import rf_ctrl_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NREQ-1:0]                  req_valid,
   input  logic [NREQ-1:0][REG_IDX_W-1:0]   req_reg,
   input  logic [NREQ-1:0][DATA_W-1:0]      req_data,
   output logic [NREQ-1:0]                  req_ready,
   output logic                             RegWrite,
   output logic [REG_IDX_W-1:0]             write_reg,
   output logic [DATA_W-1:0]                write_data,
   input  logic                             issue_valid,
   input  logic [REG_IDX_W-1:0]             issue_reg,
   output logic                             issue_ready,
   input  logic [REG_IDX_W-1:0]             query_reg1,
   input  logic [REG_IDX_W-1:0]             query_reg2,
   output logic                             query_busy1,
   output logic                             query_busy2
);
   localparam int IDX_W = $clog2(NREQ);

   logic [NREQ-1:0]      req_live;
   logic [NREQ-1:0]      gnt;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_valid;
   wb_req_t              win_req;
   logic [IDX_W-1:0]     last_grant_q, last_grant_d;
   logic                 regwrite_q, regwrite_d;
   logic [REG_IDX_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0]    write_data_q, write_data_d;

   // Handshake: a transfer happens in a cycle where req_valid[i] and req_ready[i]
   // are both high; a requester holds valid/reg/data stable until that cycle.
   // No grant is offered while reset is asserted.
   assign req_live = req_valid & {NREQ{rst}};

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i   (req_live),
      .last_i  (last_grant_q),
      .gnt_o   (gnt),
      .idx_o   (gnt_idx),
      .valid_o (gnt_valid)
   );

   assign req_ready = gnt;

   always_comb begin
      win_req.reg_idx = req_reg[gnt_idx];
      win_req.data    = req_data[gnt_idx];
   end

   // A write to $0 still consumes the grant and updates write_reg/write_data.
   always_comb begin
      last_grant_d = last_grant_q;
      regwrite_d   = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (gnt_valid) begin
         last_grant_d = gnt_idx;
         regwrite_d   = (win_req.reg_idx != '0);
         write_reg_d  = win_req.reg_idx;
         write_data_d = win_req.data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= IDX_W'(NREQ - 1);
         regwrite_q   <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         regwrite_q   <= regwrite_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign RegWrite   = regwrite_q;
   assign write_reg  = write_reg_q;
   assign write_data = write_data_q;

`ifdef RF_SCOREBOARD_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                           issue_fire;

   // A write landing on issue_reg this cycle frees a slot for the new issue.
   assign issue_ready = (issue_reg == '0) || (cnt_q[issue_reg] != CNT_MAX) ||
                        (regwrite_q && (write_reg_q == issue_reg));
   assign issue_fire  = issue_valid && issue_ready && (issue_reg != '0);

   always_comb begin
      cnt_d = cnt_q;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (issue_fire && (issue_reg == REG_IDX_W'(r)) &&
             !(regwrite_q && (write_reg_q == REG_IDX_W'(r)))) begin
            cnt_d[r] = cnt_q[r] + CNT_W'(1);
         end else if (!(issue_fire && (issue_reg == REG_IDX_W'(r))) &&
                      regwrite_q && (write_reg_q == REG_IDX_W'(r)) &&
                      (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   // The final outstanding write releases the register in the cycle it lands.
   assign query_busy1 = (cnt_q[query_reg1] != '0) &&
                        !(regwrite_q && (write_reg_q == query_reg1) && (cnt_q[query_reg1] == CNT_W'(1)));
   assign query_busy2 = (cnt_q[query_reg2] != '0) &&
                        !(regwrite_q && (write_reg_q == query_reg2) && (cnt_q[query_reg2] == CNT_W'(1)));
`else
   logic unused_sb;

   assign unused_sb   = ^{issue_valid, issue_reg, query_reg1, query_reg2};
   assign issue_ready = 1'b1;
   assign query_busy1 = 1'b0;
   assign query_busy2 = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a cycle-level
// reference model; scoreboard expectations follow RF_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;
   import rf_ctrl_pkg::*;

   localparam int NREQ = 3;
   localparam int CNTM = 3;
`ifdef RF_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic                           clk, rst;
   logic [NREQ-1:0]                req_valid;
   logic [NREQ-1:0][REG_IDX_W-1:0] req_reg;
   logic [NREQ-1:0][DATA_W-1:0]    req_data;
   logic [NREQ-1:0]                req_ready;
   logic                           RegWrite;
   logic [REG_IDX_W-1:0]           write_reg;
   logic [DATA_W-1:0]              write_data;
   logic                           issue_valid;
   logic [REG_IDX_W-1:0]           issue_reg;
   logic                           issue_ready;
   logic [REG_IDX_W-1:0]           query_reg1, query_reg2;
   logic                           query_busy1, query_busy2;

   regfile_wb_arbiter #(.NREQ(NREQ), .CNT_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_reg     (req_reg),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .RegWrite    (RegWrite),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .issue_valid (issue_valid),
      .issue_reg   (issue_reg),
      .issue_ready (issue_ready),
      .query_reg1  (query_reg1),
      .query_reg2  (query_reg2),
      .query_busy1 (query_busy1),
      .query_busy2 (query_busy2)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model state
   int          errors, checks;
   int          m_last, last_win;
   bit          m_rw;
   logic [4:0]  m_wreg;
   logic [31:0] m_wdata;
   int          m_cnt[32];
   logic [36:0] exp_q[$];
   logic [4:0]  pend_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last = NREQ - 1;
      last_win = -1;
      m_rw = 1'b0;
      m_wreg = '0;
      m_wdata = '0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      exp_q.delete();
      pend_q.delete();
   endtask

   function automatic int winner();
      for (int k = 1; k <= NREQ; k++)
         if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
      return -1;
   endfunction

   function automatic logic exp_issue_ready();
      if (!SB) return 1'b1;
      return (issue_reg == 0) || (m_cnt[issue_reg] < CNTM) || (m_rw && m_wreg == issue_reg);
   endfunction

   function automatic logic exp_busy(input logic [4:0] q);
      if (!SB) return 1'b0;
      return (m_cnt[q] != 0) && !(m_rw && m_wreg == q && m_cnt[q] == 1);
   endfunction

   function automatic logic [4:0] pick_safe();
      logic [4:0] r;
      r = 5'($urandom_range(1, 31));
      for (int t = 0; t < 64 && m_cnt[r] >= CNTM; t++) r = 5'($urandom_range(1, 31));
      return r;
   endfunction

   // compare every DUT output with the model, a little after the falling edge
   task automatic settle_and_check();
      logic [31:0] er;
      logic [36:0] e;
      int w;
      #1;
      w = winner();
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      check("req_ready", req_ready, er);
      check("issue_ready", issue_ready, exp_issue_ready());
      check("busy1", query_busy1, exp_busy(query_reg1));
      check("busy2", query_busy2, exp_busy(query_reg2));
      check("RegWrite", RegWrite, m_rw);
      if (m_rw) begin
         e = exp_q.pop_front();
         check("wb_reg", write_reg, e[36:32]);
         check("wb_data", write_data, e[31:0]);
      end else begin
         check("hold_reg", write_reg, m_wreg);
         check("hold_data", write_data, m_wdata);
      end
   endtask

   // step the model over one rising edge, then return at the falling edge
   task automatic advance();
      int w;
      bit acc;
      w = winner();
      if (SB && m_rw && m_cnt[m_wreg] == 0) begin
         errors++;
         $error("FAIL protocol_underflow reg=%0d observed=0 expected>0", m_wreg);
      end
      acc = issue_valid && exp_issue_ready() && (issue_reg != 0);
      if (m_rw && m_cnt[m_wreg] > 0) m_cnt[m_wreg]--;
      if (acc) begin
         m_cnt[issue_reg]++;
         pend_q.push_back(issue_reg);
      end
      if (w >= 0) begin
         m_last = w;
         m_rw = (req_reg[w] != 0);
         m_wreg = req_reg[w];
         m_wdata = req_data[w];
         if (m_rw) exp_q.push_back({req_reg[w], req_data[w]});
      end else begin
         m_rw = 1'b0;
      end
      last_win = w;
      @(posedge clk);
      @(negedge clk);
      if (w >= 0) req_valid[w] = 1'b0;
   endtask

   // driver tasks
   task automatic present(input int i, input logic [4:0] r, input logic [31:0] d);
      req_valid[i] = 1'b1;
      req_reg[i] = r;
      req_data[i] = d;
   endtask

   task automatic issue_cycle(input logic [4:0] r);
      issue_valid = 1'b1;
      issue_reg = r;
      settle_and_check();
      advance();
      issue_valid = 1'b0;
   endtask

   task automatic rand_cycle(input int refill_pct, input int issue_pct, input int zero_pct);
      for (int i = 0; i < NREQ; i++) begin
         if (!req_valid[i] && $urandom_range(0, 99) < refill_pct) begin
            if (pend_q.size() > 0 && $urandom_range(0, 99) >= zero_pct)
               present(i, pend_q.pop_front(), $urandom);
            else
               present(i, 5'd0, $urandom);
         end
      end
      issue_valid = ($urandom_range(0, 99) < issue_pct);
      issue_reg = 5'($urandom_range(0, 31));
      query_reg1 = (pend_q.size() > 0) ? pend_q[0] : 5'($urandom_range(0, 31));
      query_reg2 = 5'($urandom_range(0, 31));
      settle_and_check();
      advance();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req_valid = '0;
      issue_valid = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      model_reset();
      rst = 1'b0;
      req_valid = 3'b111;
      req_reg = '0;
      req_data = '0;
      issue_valid = 1'b0;
      issue_reg = '0;
      query_reg1 = 5'd3;
      query_reg2 = '0;

      // reset state, with requests held to show no grant during reset
      @(posedge clk);
      #1;
      check("rst_RegWrite", RegWrite, 0);
      check("rst_write_reg", write_reg, 0);
      check("rst_write_data", write_data, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_issue_ready", issue_ready, 1);
      check("rst_busy1", query_busy1, 0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b1;

      // single write with RAW tracking on reg 5
      query_reg1 = 5'd5;
      issue_cycle(5'd5);
      present(0, 5'd5, 32'hDEADBEEF);
      settle_and_check();
      check("single_gnt", req_ready, 3'b001);
      check("raw_busy_before", query_busy1, SB);
      advance();
      settle_and_check();
      check("single_rw", RegWrite, 1);
      check("single_reg", write_reg, 5);
      check("single_data", write_data, 32'hDEADBEEF);
      check("raw_busy_wb", query_busy1, 0);
      advance();
      settle_and_check();
      check("single_idle", RegWrite, 0);
      advance();

      // write to $0 is consumed but never written
      present(1, 5'd0, 32'h1234_5678);
      settle_and_check();
      check("zero_gnt", req_ready, 3'b010);
      advance();
      settle_and_check();
      check("zero_rw", RegWrite, 0);
      advance();

      // two outstanding writes to reg 7
      query_reg1 = 5'd7;
      issue_cycle(5'd7);
      issue_cycle(5'd7);
      present(2, 5'd7, 32'hA5A5_0001);
      settle_and_check();
      check("raw2_busy_pending", query_busy1, SB);
      advance();
      present(2, 5'd7, 32'hA5A5_0002);
      settle_and_check();
      check("raw2_busy_first", query_busy1, SB);
      advance();
      settle_and_check();
      check("raw2_busy_last", query_busy1, 0);
      advance();

      // saturation of reg 9, then issue colliding with its write
      query_reg1 = 5'd9;
      issue_cycle(5'd9);
      issue_cycle(5'd9);
      issue_cycle(5'd9);
      issue_valid = 1'b1;
      issue_reg = 5'd9;
      settle_and_check();
      check("sat_ready", issue_ready, !SB);
      advance();
      present(0, 5'd9, 32'h0000_0999);
      settle_and_check();
      advance();
      settle_and_check();
      check("collide_ready", issue_ready, 1);
      check("collide_rw", RegWrite, 1);
      advance();
      settle_and_check();
      check("collide_cnt_held", issue_ready, !SB);
      check("collide_busy", query_busy1, SB);
      advance();
      issue_valid = 1'b0;

      // round-robin fairness from reset, no bubbles
      do_reset();
      for (int k = 0; k < NREQ; k++) issue_cycle(pick_safe());
      for (int i = 0; i < NREQ; i++) present(i, pend_q.pop_front(), $urandom);
      for (int k = 0; k < 8; k++) begin
         issue_valid = 1'b1;
         issue_reg = pick_safe();
         settle_and_check();
         check("rr_fair", req_ready, 32'(1) << (k % NREQ));
         if (k > 0) check("rr_nobubble", RegWrite, 1);
         advance();
         present(last_win, pend_q.pop_front(), $urandom);
      end

      // asynchronous reset between edges mid-burst
      issue_valid = 1'b0;
      query_reg1 = req_reg[0];
      #2;
      rst = 1'b0;
      #1;
      check("arst_rw", RegWrite, 0);
      check("arst_wreg", write_reg, 0);
      check("arst_ready", req_ready, 0);
      check("arst_issue_ready", issue_ready, 1);
      check("arst_busy", query_busy1, 0);
      model_reset();
      for (int i = 0; i < NREQ; i++) present(i, 5'd0, $urandom);
      @(posedge clk);
      #1;
      check("arst_hold_rw", RegWrite, 0);
      check("arst_hold_ready", req_ready, 0);
      @(negedge clk);
      rst = 1'b1;
      settle_and_check();
      check("arst_first_gnt", req_ready, 3'b001);
      advance();

      // randomized traffic
      for (int n = 0; n < 400; n++) rand_cycle(60, 70, 15);
      for (int n = 0; n < 8; n++) rand_cycle(0, 0, 0);

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
